// File: rtl/demux_sel_sequencer.sv
// demux_sel_sequencer
// Upstream control stage for the demux1to4 block. On a frame request it walks
// the enabled output channels in ascending order, keeping each one selected for
// DWELL cycles while forwarding the din bit to the demux data input. It flags
// the first cycle of each channel slot and the cycle after a frame completes,
// and in continuous mode it re-arms back-to-back with no idle gap.
module demux_sel_sequencer #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       din,
  input  logic [3:0] ch_en,
  input  logic       cont,
  output logic       a,
  output logic [1:0] s,
  output logic       busy,
  output logic       ch_strobe,
  output logic       frame_done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // Counter value on the final cycle of a channel slot.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Index of the lowest set bit; callers only use it with a non-zero mask.
  function automatic logic [1:0] lowest_idx(input logic [3:0] m);
    logic [1:0] idx;
    if (m[0]) begin
      idx = 2'd0;
    end else if (m[1]) begin
      idx = 2'd1;
    end else if (m[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

  // Keeps only the mask bits strictly above channel idx.
  function automatic logic [3:0] above_mask(input logic [3:0] m, input logic [1:0] idx);
    logic [3:0] r;
    case (idx)
      2'd0:    r = m & 4'b1110;
      2'd1:    r = m & 4'b1100;
      2'd2:    r = m & 4'b1000;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       s_q, s_d;
  logic             a_q, a_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic [3:0]       higher;

  // Next-state logic: frame start, slot advance, frame end and continuous re-arm.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    a_d      = 1'b0;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    higher   = above_mask(mask_q, s_q);

    case (state_q)
      ST_IDLE: begin
        if (start && (ch_en != 4'b0000)) begin
          mask_d   = ch_en;
          s_d      = lowest_idx(ch_en);
          cnt_d    = CNT_ZERO;
          state_d  = ST_DWELL;
          busy_d   = 1'b1;
          strobe_d = 1'b1;
          a_d      = din;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_DWELL: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
          a_d   = din;
        end else if (higher != 4'b0000) begin
          // Move on to the next enabled channel above the current one.
          s_d      = lowest_idx(higher);
          cnt_d    = CNT_ZERO;
          strobe_d = 1'b1;
          a_d      = din;
        end else begin
          done_d = 1'b1;
          if (cont && (ch_en != 4'b0000)) begin
            // Continuous mode: the next frame uses the live enable mask.
            mask_d   = ch_en;
            s_d      = lowest_idx(ch_en);
            cnt_d    = CNT_ZERO;
            strobe_d = 1'b1;
            a_d      = din;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = CNT_ZERO;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, latched mask, dwell counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= 4'b0000;
      cnt_q    <= CNT_ZERO;
      s_q      <= 2'b00;
      a_q      <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      a_q      <= a_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign a          = a_q;
  assign s          = s_q;
  assign busy       = busy_q;
  assign ch_strobe  = strobe_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Bench for demux_sel_sequencer: one instance with DWELL=4 and one with DWELL=1
// share the same stimulus; both are compared with a frame-level reference model.
module tb_demux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       din = 1'b0;
  logic [3:0] ch_en = 4'b0000;
  logic       cont = 1'b0;

  logic       a4, busy4, str4, done4;
  logic [1:0] s4;
  logic       a1, busy1, str1, done1;
  logic [1:0] s1;
  logic [5:0] obs4, obs1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_sel_sequencer #(.DWELL(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start), .din(din), .ch_en(ch_en), .cont(cont),
    .a(a4), .s(s4), .busy(busy4), .ch_strobe(str4), .frame_done(done4)
  );

  demux_sel_sequencer #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .start(start), .din(din), .ch_en(ch_en), .cont(cont),
    .a(a1), .s(s1), .busy(busy1), .ch_strobe(str1), .frame_done(done1)
  );

  assign obs4 = {a4, s4, busy4, str4, done4};
  assign obs1 = {a1, s1, busy1, str1, done1};

  // Reference model: a frame is a list of enabled channels, visited in order,
  // each held for dw cycles.
  typedef struct packed {
    logic [3:0][1:0] list;
    logic [2:0]      n;
    logic [2:0]      idx;
    logic [7:0]      k;
    logic            busy;
    logic [1:0]      s;
    logic            a;
    logic            strobe;
    logic            done;
  } model_t;

  model_t m4, m1;

  function automatic model_t m_begin(logic [3:0] en, logic d);
    model_t r = '0;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        r.list[n] = 2'(i);
        n++;
      end
    end
    r.n      = 3'(n);
    r.s      = r.list[0];
    r.busy   = 1'b1;
    r.strobe = 1'b1;
    r.a      = d;
    return r;
  endfunction

  function automatic model_t m_step(model_t m, int dw, logic st, logic d, logic [3:0] en, logic ct);
    model_t r = m;
    r.strobe = 1'b0;
    r.done   = 1'b0;
    r.a      = 1'b0;
    if (!m.busy) begin
      if (st && en != 4'b0000) r = m_begin(en, d);
    end else if (int'(m.k) < dw - 1) begin
      r.k = m.k + 8'd1;
      r.a = d;
    end else if (int'(m.idx) < int'(m.n) - 1) begin
      r.idx    = m.idx + 3'd1;
      r.k      = 8'd0;
      r.s      = m.list[r.idx[1:0]];
      r.strobe = 1'b1;
      r.a      = d;
    end else begin
      if (ct && en != 4'b0000) r = m_begin(en, d);
      else r.busy = 1'b0;
      r.done = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [5:0] pk(model_t m);
    return {m.a, m.s, m.busy, m.strobe, m.done};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= '0;
      m1 <= '0;
    end else begin
      m4 <= m_step(m4, 4, start, din, ch_en, cont);
      m1 <= m_step(m1, 1, start, din, ch_en, cont);
    end
  end

  task automatic settle();
    start = 1'b0;
    cont  = 1'b0;
    din   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 60 && (m4.busy || m1.busy); i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    start = 1'b0; din = 1'b0; ch_en = 4'b0000; cont = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs4 !== 6'b0) begin errors++; $display("FAIL reset_init4 got=%b exp=%b", obs4, 6'b0); end
    checks++;
    if (obs1 !== 6'b0) begin errors++; $display("FAIL reset_init1 got=%b exp=%b", obs1, 6'b0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ch_en = 4'b1111; din = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got=%b exp=1", busy4); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs4 !== 6'b0) begin errors++; $display("FAIL reset_mid4 got=%b exp=%b", obs4, 6'b0); end
    checks++;
    if (obs1 !== 6'b0) begin errors++; $display("FAIL reset_mid1 got=%b exp=%b", obs1, 6'b0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    logic [5:0] ex;
    ch_en = 4'b1111; cont = 1'b0; din = 1'b1; start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      ex[5]   = (c <= 16);
      ex[4:3] = (c <= 16) ? 2'((c - 1) / 4) : 2'd3;
      ex[2]   = (c <= 16);
      ex[1]   = (c <= 16) && ((c - 1) % 4 == 0);
      ex[0]   = (c == 17);
      checks++;
      if (obs4 !== ex) begin errors++; $display("FAIL full_frame c=%0d got=%b exp=%b", c, obs4, ex); end
      checks++;
      if (obs1 !== pk(m1)) begin errors++; $display("FAIL full_frame_d1 c=%0d got=%b exp=%b", c, obs1, pk(m1)); end
    end
  endtask

  task automatic test_sparse();
    logic [5:0] ex;
    ch_en = 4'b1010; cont = 1'b0; din = 1'b1; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      ex[5]   = (c <= 8);
      ex[4:3] = (c <= 4) ? 2'd1 : 2'd3;
      ex[2]   = (c <= 8);
      ex[1]   = (c == 1) || (c == 5);
      ex[0]   = (c == 9);
      checks++;
      if (obs4 !== ex) begin errors++; $display("FAIL sparse c=%0d got=%b exp=%b", c, obs4, ex); end
      checks++;
      if (obs1 !== pk(m1)) begin errors++; $display("FAIL sparse_d1 c=%0d got=%b exp=%b", c, obs1, pk(m1)); end
    end
  endtask

  task automatic test_cont();
    logic [5:0] ex;
    ch_en = 4'b0001; cont = 1'b1; din = 1'b1; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      ex[5]   = (c <= 12);
      ex[4:3] = 2'd0;
      ex[2]   = (c <= 12);
      ex[1]   = (c == 1) || (c == 5) || (c == 9);
      ex[0]   = (c == 5) || (c == 9) || (c == 13);
      checks++;
      if (obs4 !== ex) begin errors++; $display("FAIL cont c=%0d got=%b exp=%b", c, obs4, ex); end
      checks++;
      if (obs1 !== pk(m1)) begin errors++; $display("FAIL cont_d1 c=%0d got=%b exp=%b", c, obs1, pk(m1)); end
      if (c == 10) cont = 1'b0;
    end
  endtask

  task automatic test_ignored();
    logic [5:0] ex;
    ch_en = 4'b0000; cont = 1'b0; din = 1'b1; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if ({a4, busy4, str4, done4, a1, busy1, str1, done1} !== 8'b0) begin
        errors++;
        $display("FAIL empty_start c=%0d got=%b exp=%b", c, {a4, busy4, str4, done4, a1, busy1, str1, done1}, 8'b0);
      end
    end
    start = 1'b0;
    @(negedge clk);
    ch_en = 4'b1111; start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
      ex[5]   = (c <= 16);
      ex[4:3] = (c <= 16) ? 2'((c - 1) / 4) : 2'd3;
      ex[2]   = (c <= 16);
      ex[1]   = (c <= 16) && ((c - 1) % 4 == 0);
      ex[0]   = (c == 17);
      checks++;
      if (obs4 !== ex) begin errors++; $display("FAIL ignored c=%0d got=%b exp=%b", c, obs4, ex); end
      checks++;
      if (obs1 !== pk(m1)) begin errors++; $display("FAIL ignored_d1 c=%0d got=%b exp=%b", c, obs1, pk(m1)); end
      if (c == 2) ch_en = 4'b0001;
      if (c == 3) start = 1'b1;
    end
  endtask

  task automatic test_din(input logic [3:0] pat);
    logic prev;
    ch_en = 4'b0001; cont = 1'b0; start = 1'b1; din = pat[0];
    prev = pat[0];
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (a4 !== ((c <= 4) ? prev : 1'b0)) begin
        errors++;
        $display("FAIL din_follow c=%0d got=%b exp=%b", c, a4, (c <= 4) ? prev : 1'b0);
      end
      din  = (c < 4) ? pat[c] : 1'b0;
      prev = din;
    end
  endtask

  task automatic test_dwell1(input logic [3:0] en);
    int lst[4];
    int n = 0;
    for (int i = 0; i < 4; i++) if (en[i]) begin lst[n] = i; n++; end
    ch_en = en; cont = 1'b0; din = 1'b1; start = 1'b1;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (c <= n) begin
        if ({s1, busy1, str1, done1} !== {2'(lst[c - 1]), 3'b110}) begin
          errors++;
          $display("FAIL dwell1 en=%b c=%0d got=%b exp=%b", en, c, {s1, busy1, str1, done1}, {2'(lst[c - 1]), 3'b110});
        end
      end else begin
        if ({busy1, str1, done1} !== 3'b001) begin
          errors++;
          $display("FAIL dwell1_end en=%b c=%0d got=%b exp=%b", en, c, {busy1, str1, done1}, 3'b001);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(5) == 0);
      din   = 1'($urandom_range(1));
      ch_en = 4'($urandom_range(15));
      cont  = ($urandom_range(3) == 0);
      @(negedge clk);
      checks++;
      if (obs4 !== pk(m4)) begin errors++; $display("FAIL random_d4 c=%0d got=%b exp=%b", c, obs4, pk(m4)); end
      checks++;
      if (obs1 !== pk(m1)) begin errors++; $display("FAIL random_d1 c=%0d got=%b exp=%b", c, obs1, pk(m1)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    settle();
    test_full_frame();
    settle();
    test_sparse();
    settle();
    test_cont();
    settle();
    test_ignored();
    settle();
    test_din(4'b0101);
    settle();
    test_din(4'($urandom_range(15)));
    settle();
    for (int i = 0; i < 6; i++) begin
      test_dwell1(4'($urandom_range(14) + 1));
      settle();
    end
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
